// File: rtl/instruction_fetcher_pkg.sv
// instruction_fetcher_pkg: opcode constants, fetch FSM states, queue entry width and immediate decoders
package instruction_fetcher_pkg;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam int ENTRY_W = 65;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} fetch_state_t;
  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: power-of-two FIFO with enqueue, dequeue and clear; head reads as zero when empty
module fetch_queue
  import instruction_fetcher_pkg::*;
#(
  parameter int DEPTH_LOG = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr,
  input  logic enq,
  input  logic deq,
  input  logic [WIDTH-1:0] enq_data,
  output logic [WIDTH-1:0] deq_data,
  output logic valid,
  output logic full
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG:0] count;
  assign valid = count != '0;
  assign full = count[DEPTH_LOG];
  assign deq_data = valid ? mem[rd_ptr] : '0;
  // storage is written only on enqueue and never needs a reset
  always_ff @(posedge clk_in)
    if (enq) mem[wr_ptr] <= enq_data;
  // pointers wrap naturally at the power-of-two depth; count keeps full/empty exact
  always_ff @(posedge clk_in)
    if (!rst_in || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (DEPTH_LOG+1)'(enq) - (DEPTH_LOG+1)'(deq);
    end
endmodule

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: one-outstanding icache fetch loop with next-PC prediction and an instruction queue; FETCH_BRANCH_PREDICT_EN enables predictor-driven branches
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int QUEUE_DEPTH_LOG = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  output logic icache_req_valid,
  output logic [31:0] icache_req_addr,
  input  logic icache_resp_valid,
  input  logic [31:0] icache_resp_inst,
  output logic pred_query_en,
  output logic [31:0] pred_query_PC,
  input  logic pred_result_in,
  output logic inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] inst_PC_out,
  output logic inst_pred_taken_out,
  input  logic inst_ready_in,
  input  logic flush_en,
  input  logic [31:0] flush_PC
);
  fetch_state_t state, state_nx;
  logic [31:0] pc, pc_nx, pc_tgt;
  logic run, live, resp_hit, is_branch, is_jal, taken, full, enq, deq, clr;
  logic [ENTRY_W-1:0] head;
  assign run = rst_in && rdy_in;
  assign live = run && !flush_en;
  assign resp_hit = live && state == S_WAIT && icache_resp_valid;
  assign is_branch = icache_resp_inst[6:0] == OPC_BRANCH;
  assign is_jal = icache_resp_inst[6:0] == OPC_JAL;
`ifdef FETCH_BRANCH_PREDICT_EN
  assign pred_query_en = resp_hit && is_branch;
  assign taken = is_jal || (is_branch && pred_result_in);
`else
  logic pred_unused;
  assign pred_unused = pred_result_in;
  assign pred_query_en = 1'b0;
  assign taken = is_jal;
`endif
  assign pred_query_PC = pc;
  assign pc_tgt = taken ? pc + (is_jal ? imm_j(icache_resp_inst) : imm_b(icache_resp_inst)) : pc + 32'd4;
  assign icache_req_addr = pc;
  assign deq = live && inst_valid_out && inst_ready_in;
  assign enq = resp_hit;
  assign clr = run && flush_en;
  assign icache_req_valid = live && state == S_REQ && (!full || deq);
  assign {inst_out, inst_PC_out, inst_pred_taken_out} = head;
  fetch_queue #(.DEPTH_LOG(QUEUE_DEPTH_LOG), .WIDTH(ENTRY_W)) u_queue (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .clr(clr),
    .enq(enq),
    .deq(deq),
    .enq_data({icache_resp_inst, pc, taken}),
    .deq_data(head),
    .valid(inst_valid_out),
    .full(full)
  );
  // next state and PC: flush redirects and may leave one in-flight response to drop
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    if (flush_en) begin
      state_nx = (state == S_REQ || icache_resp_valid) ? S_REQ : S_DROP;
      pc_nx = flush_PC;
    end else begin
      state_nx = state == S_REQ ? (icache_req_valid ? S_WAIT : S_REQ) : icache_resp_valid ? S_REQ : state;
      pc_nx = enq ? pc_tgt : pc;
    end
  end
  // state register, frozen while rdy_in is low
  always_ff @(posedge clk_in)
    if (!rst_in) begin
      state <= S_REQ;
      pc <= RESET_PC;
    end else if (rdy_in) begin
      state <= state_nx;
      pc <= pc_nx;
    end
endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: directed and randomized checks of the fetcher against a queue-based reference model
module tb_instruction_fetcher;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int DEPTH = 4;
`ifdef FETCH_BRANCH_PREDICT_EN
  localparam bit PRED_ON = 1'b1;
`else
  localparam bit PRED_ON = 1'b0;
`endif
  logic clk_in = 0, rst_in, rdy_in, icache_req_valid, icache_resp_valid, pred_query_en, pred_result_in;
  logic inst_valid_out, inst_pred_taken_out, inst_ready_in, flush_en;
  logic [31:0] icache_req_addr, icache_resp_inst, pred_query_PC, inst_out, inst_PC_out, flush_PC;
  int vectors = 0, miscompares = 0, cyc = 0;

  instruction_fetcher dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
    .icache_resp_valid(icache_resp_valid), .icache_resp_inst(icache_resp_inst),
    .pred_query_en(pred_query_en), .pred_query_PC(pred_query_PC), .pred_result_in(pred_result_in),
    .inst_valid_out(inst_valid_out), .inst_out(inst_out), .inst_PC_out(inst_PC_out),
    .inst_pred_taken_out(inst_pred_taken_out), .inst_ready_in(inst_ready_in),
    .flush_en(flush_en), .flush_PC(flush_PC)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [31:0] enc_b(input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic redirect(input logic [31:0] p);
    flush_en = 1;
    flush_PC = p;
    step();
    flush_en = 0;
    #1;
  endtask

  task automatic fetch_one(input logic [31:0] inst, input int lat, input logic pred,
                           output logic [31:0] addr, output int at, output logic qen, output logic [31:0] qpc);
    int n = 0;
    addr = 'x;
    at = -1;
    qen = 'x;
    qpc = 'x;
    while (!icache_req_valid && n < 40) begin
      step();
      n++;
    end
    if (icache_req_valid) begin
      addr = icache_req_addr;
      at = cyc;
      step();
      repeat (lat) step();
      icache_resp_valid = 1;
      icache_resp_inst = inst;
      pred_result_in = pred;
      #1;
      qen = pred_query_en;
      qpc = pred_query_PC;
      step();
      icache_resp_valid = 0;
      pred_result_in = 0;
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    vectors++; if (icache_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b exp 0", icache_req_valid); end
    vectors++; if (pred_query_en !== 1'b0) begin miscompares++; $display("FAIL rst_qen got %b exp 0", pred_query_en); end
    vectors++; if (inst_valid_out !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", inst_valid_out); end
    vectors++; if ({inst_out, inst_PC_out, inst_pred_taken_out} !== 65'h0) begin miscompares++; $display("FAIL rst_head got %h exp 0", {inst_out, inst_PC_out, inst_pred_taken_out}); end
    rst_in = 1;
    flush_en = 0;
    icache_resp_valid = 0;
    #1;
    vectors++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h0) begin miscompares++; $display("FAIL rst_first_req got %b/%h exp 1/00000000", icache_req_valid, icache_req_addr); end
    vectors++; if (inst_valid_out !== 1'b0) begin miscompares++; $display("FAIL rst_resp_dropped got %b exp 0", inst_valid_out); end
  endtask

  task automatic test_nop_stream();
    logic [31:0] a, q;
    logic qe;
    int at, last = 0;
    inst_ready_in = 1;
    for (int i = 0; i < 3; i++) begin
      fetch_one(NOP, 0, 0, a, at, qe, q);
      vectors++; if (a !== 32'(i * 4)) begin miscompares++; $display("FAIL nop_addr%0d got %h exp %h", i, a, 32'(i * 4)); end
      if (i > 0) begin
        vectors++; if (at - last !== 2) begin miscompares++; $display("FAIL nop_spacing%0d got %0d exp 2", i, at - last); end
      end
      last = at;
      vectors++; if (inst_valid_out !== 1'b1 || inst_PC_out !== 32'(i * 4) || inst_out !== NOP) begin miscompares++; $display("FAIL nop_head%0d got %b/%h/%h exp 1/%h/%h", i, inst_valid_out, inst_PC_out, inst_out, 32'(i * 4), NOP); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] a, q, exp_nxt;
    logic qe;
    int at;
    inst_ready_in = 1;
    redirect(32'h10);
    fetch_one(enc_b(32'hFFFF_FFF8), 1, 1'b1, a, at, qe, q);
    exp_nxt = PRED_ON ? 32'h08 : 32'h14;
    vectors++; if (a !== 32'h10) begin miscompares++; $display("FAIL br_addr got %h exp 00000010", a); end
    vectors++; if (qe !== PRED_ON || q !== 32'h10) begin miscompares++; $display("FAIL br_query got %b/%h exp %b/00000010", qe, q, PRED_ON); end
    vectors++; if (inst_pred_taken_out !== PRED_ON || inst_PC_out !== 32'h10) begin miscompares++; $display("FAIL br_taken got %b/%h exp %b/00000010", inst_pred_taken_out, inst_PC_out, PRED_ON); end
    vectors++; if (icache_req_valid !== 1'b1 || icache_req_addr !== exp_nxt) begin miscompares++; $display("FAIL br_next_t got %b/%h exp 1/%h", icache_req_valid, icache_req_addr, exp_nxt); end
    redirect(32'h10);
    fetch_one(enc_b(32'hFFFF_FFF8), 0, 1'b0, a, at, qe, q);
    vectors++; if (inst_pred_taken_out !== 1'b0 || icache_req_addr !== 32'h14) begin miscompares++; $display("FAIL br_next_nt got %b/%h exp 0/00000014", inst_pred_taken_out, icache_req_addr); end
    redirect(32'h30);
    fetch_one(enc_b(32'h40), 0, 1'b1, a, at, qe, q);
    exp_nxt = PRED_ON ? 32'h70 : 32'h34;
    vectors++; if (qe !== PRED_ON || icache_req_addr !== exp_nxt) begin miscompares++; $display("FAIL br30 got %b/%h exp %b/%h", qe, icache_req_addr, PRED_ON, exp_nxt); end
  endtask

  task automatic test_jal();
    logic [31:0] a, q;
    logic qe;
    int at;
    redirect(32'h20);
    fetch_one(enc_j(32'h100), 2, 1'b1, a, at, qe, q);
    vectors++; if (qe !== 1'b0) begin miscompares++; $display("FAIL jal_query got %b exp 0", qe); end
    vectors++; if (inst_pred_taken_out !== 1'b1 || inst_PC_out !== 32'h20) begin miscompares++; $display("FAIL jal_head got %b/%h exp 1/00000020", inst_pred_taken_out, inst_PC_out); end
    vectors++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h120) begin miscompares++; $display("FAIL jal_next got %b/%h exp 1/00000120", icache_req_valid, icache_req_addr); end
  endtask

  task automatic test_queue_full();
    logic [31:0] a, q, e;
    logic qe;
    int at, hi = 0;
    logic [31:0] sb[$];
    inst_ready_in = 0;
    redirect(32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      fetch_one(NOP, i % 2, 0, a, at, qe, q);
      vectors++; if (a !== 32'(i * 4)) begin miscompares++; $display("FAIL full_fill%0d got %h exp %h", i, a, 32'(i * 4)); end
      sb.push_back(32'(i * 4));
    end
    for (int i = 0; i < 10; i++) begin
      if (icache_req_valid) hi++;
      step();
    end
    vectors++; if (hi !== 0) begin miscompares++; $display("FAIL full_stall got %0d req cycles exp 0", hi); end
    inst_ready_in = 1;
    #1;
    vectors++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h10) begin miscompares++; $display("FAIL full_reopen got %b/%h exp 1/00000010", icache_req_valid, icache_req_addr); end
    step();
    void'(sb.pop_front());
    inst_ready_in = 0;
    icache_resp_valid = 1;
    icache_resp_inst = NOP;
    step();
    icache_resp_valid = 0;
    sb.push_back(32'h10);
    #1;
    vectors++; if (icache_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_again got %b exp 0", icache_req_valid); end
    inst_ready_in = 1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      e = sb.pop_front();
      vectors++; if (inst_valid_out !== 1'b1 || inst_PC_out !== e) begin miscompares++; $display("FAIL full_drain%0d got %b/%h exp 1/%h", i, inst_valid_out, inst_PC_out, e); end
      step();
    end
    icache_resp_valid = 1;
    icache_resp_inst = NOP;
    step();
    icache_resp_valid = 0;
    #1;
  endtask

  task automatic test_flush();
    logic [31:0] a, q;
    logic qe;
    int at;
    inst_ready_in = 1;
    redirect(32'h40);
    step();
    flush_en = 1;
    flush_PC = 32'h200;
    step();
    flush_en = 0;
    icache_resp_valid = 1;
    icache_resp_inst = NOP;
    #1;
    vectors++; if (icache_req_valid !== 1'b0) begin miscompares++; $display("FAIL flush_drop_req got %b exp 0", icache_req_valid); end
    step();
    icache_resp_valid = 0;
    #1;
    vectors++; if (inst_valid_out !== 1'b0) begin miscompares++; $display("FAIL flush_dropped got %b exp 0", inst_valid_out); end
    vectors++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h200) begin miscompares++; $display("FAIL flush_next got %b/%h exp 1/00000200", icache_req_valid, icache_req_addr); end
    step();
    flush_en = 1;
    flush_PC = 32'h300;
    icache_resp_valid = 1;
    icache_resp_inst = enc_j(32'h80);
    step();
    flush_en = 0;
    icache_resp_valid = 0;
    #1;
    vectors++; if (inst_valid_out !== 1'b0 || icache_req_valid !== 1'b1 || icache_req_addr !== 32'h300) begin miscompares++; $display("FAIL flush_same got %b/%b/%h exp 0/1/00000300", inst_valid_out, icache_req_valid, icache_req_addr); end
    inst_ready_in = 0;
    fetch_one(NOP, 0, 0, a, at, qe, q);
    redirect(32'h400);
    vectors++; if (inst_valid_out !== 1'b0 || icache_req_addr !== 32'h400) begin miscompares++; $display("FAIL flush_clear got %b/%h exp 0/00000400", inst_valid_out, icache_req_addr); end
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] a, q;
    logic qe;
    int at;
    inst_ready_in = 0;
    redirect(32'h500);
    fetch_one(NOP, 0, 0, a, at, qe, q);
    rdy_in = 0;
    inst_ready_in = 1;
    flush_en = 1;
    flush_PC = 32'h900;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (icache_req_valid !== 1'b0 || pred_query_en !== 1'b0) begin miscompares++; $display("FAIL freeze_strobe%0d got %b/%b exp 0/0", i, icache_req_valid, pred_query_en); end
      step();
    end
    rdy_in = 1;
    flush_en = 0;
    inst_ready_in = 0;
    #1;
    vectors++; if (inst_valid_out !== 1'b1 || inst_PC_out !== 32'h500) begin miscompares++; $display("FAIL freeze_head got %b/%h exp 1/00000500", inst_valid_out, inst_PC_out); end
    vectors++; if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h504) begin miscompares++; $display("FAIL freeze_pc got %b/%h exp 1/00000504", icache_req_valid, icache_req_addr); end
  endtask

  task automatic test_random();
    logic [31:0] mpc, cur_inst, imm, r;
    logic [64:0] sb[$];
    logic [64:0] e;
    int lat = 0, kind = 0, reqs = 0;
    bit waiting = 0, resp, tk, exp_req, exp_qen;
    mpc = $urandom & 32'hFFFF_FFFC;
    redirect(mpc);
    cur_inst = NOP;
    imm = 0;
    for (int c = 0; c < 3000; c++) begin
      inst_ready_in = $urandom_range(3) != 0;
      pred_result_in = 1'($urandom_range(1));
      resp = waiting && lat == 0;
      icache_resp_valid = resp;
      icache_resp_inst = cur_inst;
      #1;
      vectors++; if (inst_valid_out !== (sb.size() != 0)) begin miscompares++; $display("FAIL rnd_valid c%0d got %b exp %b", c, inst_valid_out, sb.size() != 0); end
      if (sb.size() != 0 && inst_valid_out && inst_ready_in) begin
        e = sb.pop_front();
        vectors++; if ({inst_out, inst_PC_out, inst_pred_taken_out} !== e) begin miscompares++; $display("FAIL rnd_head c%0d got %h exp %h", c, {inst_out, inst_PC_out, inst_pred_taken_out}, e); end
      end
      tk = kind == 2 || (kind == 1 && pred_result_in && PRED_ON);
      exp_qen = resp && kind == 1 && PRED_ON;
      vectors++; if (pred_query_en !== exp_qen) begin miscompares++; $display("FAIL rnd_qen c%0d got %b exp %b", c, pred_query_en, exp_qen); end
      exp_req = !waiting && sb.size() < DEPTH;
      vectors++; if (icache_req_valid !== exp_req || (exp_req && icache_req_addr !== mpc)) begin miscompares++; $display("FAIL rnd_req c%0d got %b/%h exp %b/%h", c, icache_req_valid, icache_req_addr, exp_req, mpc); end
      if (resp) begin
        sb.push_back({cur_inst, mpc, tk});
        mpc = tk ? mpc + imm : mpc + 32'd4;
        waiting = 0;
      end else if (exp_req) begin
        reqs++;
        waiting = 1;
        lat = $urandom_range(3);
        r = $urandom;
        case ($urandom_range(9))
          5, 6: begin kind = 1; imm = 32'(int'($urandom_range(32)) * 4 - 64); cur_inst = enc_b(imm); end
          7: begin kind = 2; imm = 32'(int'($urandom_range(256)) * 4 - 512); cur_inst = enc_j(imm); end
          8, 9: begin kind = 0; cur_inst = {r[31:7], 7'b1100111}; end
          default: begin kind = 0; cur_inst = NOP; end
        endcase
      end else if (waiting) lat--;
      step();
    end
    vectors++; if (reqs < 200) begin miscompares++; $display("FAIL rnd_progress got %0d requests exp >= 200", reqs); end
  endtask

  initial begin
    rst_in = 0;
    rdy_in = 1;
    flush_en = 1;
    flush_PC = 32'hDEAD_BEEC;
    icache_resp_valid = 1;
    icache_resp_inst = NOP;
    pred_result_in = 0;
    inst_ready_in = 1;
    test_reset();
    test_nop_stream();
    test_branch();
    test_jal();
    test_queue_full();
    test_flush();
    test_rdy_freeze();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instruction_fetcher.md
INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH_LOG, default 2, meaning fetch queue depth = 2^QUEUE_DEPTH_LOG entries.
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning the first fetch address after reset.
REQ-003 clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous, active-low.
REQ-005 rdy_in  input  1  global run enable; low freezes all state.
REQ-006 icache_req_valid  output  1  fetch request strobe.
REQ-007 icache_req_addr  output  32  fetch address, word aligned.
REQ-008 icache_resp_valid  input  1  instruction return strobe.
REQ-009 icache_resp_inst  input  32  returned instruction word.
REQ-010 pred_query_en  output  1  predictor query strobe.
REQ-011 pred_query_PC  output  32  PC being predicted.
REQ-012 pred_result_in  input  1  predictor answer, combinational, 1 = taken.
REQ-013 inst_valid_out  output  1  queue head valid.
REQ-014 inst_out, inst_PC_out  output  32 each  queue head instruction and its PC.
REQ-015 inst_pred_taken_out  output  1  prediction recorded for the queue head.
REQ-016 inst_ready_in  input  1  consumer accepts the head this cycle.
REQ-017 flush_en, flush_PC  input  1/32  mispredict redirect from RoB.

Function
REQ-018 SHALL implement FSM states S_REQ, S_WAIT, S_DROP, with at most one outstanding icache request.
REQ-019 In S_REQ: SHALL assert icache_req_valid for exactly one cycle, with icache_req_addr = PC, only when the queue has at least one free slot after this cycle's dequeue; SHALL then enter S_WAIT; with no free slot it SHALL stay in S_REQ with the request low.
REQ-020 In S_WAIT with icache_resp_valid: SHALL enqueue {inst, PC, pred_taken} on that edge, update PC, and return to S_REQ (two-cycle minimum fetch loop).
REQ-021 Opcode 1100011 (branch): pred_query_en = 1 and pred_query_PC = PC in the response cycle; next PC = pred_result_in ? PC + immB : PC + 4; pred_taken = pred_result_in.
REQ-022 Opcode 1101111 (JAL): next PC = PC + immJ; pred_taken = 1; no predictor query.
REQ-023 All other opcodes, including JALR: next PC = PC + 4; pred_taken = 0.
REQ-024 Immediates SHALL be sign-extended to 32 bits; address arithmetic SHALL wrap modulo 2^32.
REQ-025 pred_query_en SHALL be 0 in every cycle that has no branch response.
REQ-026 Dequeue SHALL occur when inst_valid_out && inst_ready_in; enqueue and dequeue in the same cycle SHALL leave the count unchanged.
REQ-027 Queue pointers SHALL wrap modulo depth; the full and empty conditions SHALL be exact.
REQ-028 flush_en SHALL have priority over all other events: the queue is emptied, PC <= flush_PC, and no enqueue or dequeue takes effect that cycle.
REQ-029 On flush in S_WAIT without a same-cycle response: SHALL enter S_DROP, discard the next response, then enter S_REQ.
REQ-030 On flush in S_WAIT with a same-cycle response: SHALL discard that response and enter S_REQ.
REQ-031 On flush in S_REQ or S_DROP: SHALL enter S_REQ (from S_DROP, S_DROP is retained if no response has arrived yet).
REQ-032 rdy_in = 0: SHALL not change state; icache_req_valid and pred_query_en SHALL be 0; queue outputs SHALL hold.

Reset
REQ-033 On rst_in = 0 at a clock edge: PC <= RESET_PC; queue empty; state S_REQ; all outputs 0.
REQ-034 Reset SHALL override rdy_in and flush_en; a response arriving during reset SHALL be discarded.

Configuration
REQ-035 Macro FETCH_BRANCH_PREDICT_EN defined: behaviour per REQ-021.
REQ-036 Macro undefined: pred_query_en is tied to 0, branches are treated as not taken (PC + 4, pred_taken = 0), and JAL still redirects.

Structure
REQ-037 A shared package SHALL hold the opcode constants (OPC_BRANCH, OPC_JAL, OPC_JALR) and the FSM state encodings.
REQ-038 The queue SHALL be a sub-module fetch_queue (parameterised FIFO with enq/deq/clear); next-PC logic stays in instruction_fetcher.

Verification
REQ-039 Reset, then a NOP stream with inst_ready_in = 1 -> requests at 0x0, 0x4, 0x8, one every 2 cycles.
REQ-040 beq at 0x10 with immB = -8 and pred_result_in = 1 -> pred_query_PC = 0x10, next request 0x08, pred_taken = 1; with pred_result_in = 0 -> next request 0x14.
REQ-041 JAL at 0x20 with immJ = +0x100 -> next request 0x120, pred_taken = 1, pred_query_en = 0.
REQ-042 inst_ready_in = 0 with depth 4 -> exactly 4 entries enqueued, then icache_req_valid stays 0 until one dequeue.
REQ-043 flush_en with flush_PC = 0x200 in S_WAIT, response one cycle later -> that response is not enqueued, queue empty, next request 0x200.
REQ-044 FETCH_BRANCH_PREDICT_EN undefined and a branch at 0x30 -> pred_query_en = 0, next request 0x34.
